// File: rtl/ahb_timer_slave_if.sv
// ahb_timer_slave_if: AHB-Lite bus bundle between the system fabric and the Timer1 slave
interface ahb_timer_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_timer_slave.sv
// ahb_timer_slave: AHB slave with a prescaled 32-bit down-counter, periodic/one-shot modes and maskable IRQ
module ahb_timer_slave #(
    parameter logic [31:0] LOAD_RST     = 32'h0000_0000,
    parameter logic [7:0]  PRESCALE_RST = 8'h00
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_timer_slave_if.slave bus,
    output logic             TIMINT
);
    typedef enum logic [1:0] {OK, ERR1, ERR2} state_t;
    state_t      state_q, state_d;
    logic        dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
    logic [1:0]  dp_off_q, dp_off_d;
    logic [31:0] load_q, load_d, value_q, value_d;
    logic        en_q, en_d, periodic_q, periodic_d, ie_q, ie_d, irq_q, irq_d;
    logic [7:0]  prescale_q, prescale_d, pcnt_q, pcnt_d;
    logic        accept, legal, wr, tick;
    logic [31:0] rd_mux;
    logic        unused_addr;

    assign accept      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign legal       = (bus.HADDR[11:4] == 8'h00) & (bus.HSIZE == 3'b010);
    assign wr          = dp_valid_q & dp_write_q & bus.HREADY;
    assign tick        = en_q & (pcnt_q == prescale_q);
    assign unused_addr = ^{bus.HADDR[31:12], bus.HADDR[1:0], bus.HTRANS[0]};

    // Error response sequencing: a wait cycle then the completing cycle, both flagged ERROR
    always_comb begin
        state_d = (state_q == ERR1) ? ERR2 : (accept & ~legal) ? ERR1 : OK;
    end

    // Address-phase capture; only legal accesses open a data phase, held while the bus is stalled
    always_comb begin
        dp_valid_d = bus.HREADY ? (accept & legal) : dp_valid_q;
        dp_write_d = (bus.HREADY & accept) ? bus.HWRITE : dp_write_q;
        dp_off_d   = (bus.HREADY & accept) ? bus.HADDR[3:2] : dp_off_q;
    end

    // Timer evolution first, then bus writes layered on top so software wins where it must
    always_comb begin
        load_d     = load_q;
        value_d    = value_q;
        en_d       = en_q;
        periodic_d = periodic_q;
        ie_d       = ie_q;
        prescale_d = prescale_q;
        irq_d      = irq_q;
        pcnt_d     = pcnt_q;
        if (wr && dp_off_q == 2'd3 && bus.HWDATA[0]) irq_d = 1'b0;
        if (en_q) pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
        if (tick) begin
            if (value_q != 32'd0) begin
                value_d = value_q - 32'd1;
            end else begin
                irq_d = 1'b1;
                if (periodic_q) value_d = load_q;
                else en_d = 1'b0;
            end
        end
        if (wr && dp_off_q == 2'd0) begin
            load_d  = bus.HWDATA;
            value_d = bus.HWDATA;
            pcnt_d  = 8'd0;
        end
        if (wr && dp_off_q == 2'd2) begin
            en_d       = bus.HWDATA[0];
            periodic_d = bus.HWDATA[1];
            ie_d       = bus.HWDATA[2];
            prescale_d = bus.HWDATA[15:8];
            if (~en_q & bus.HWDATA[0]) pcnt_d = 8'd0;
        end
    end

    // Read data is driven only during a legal read data phase
    always_comb begin
        rd_mux = (dp_off_q == 2'd0) ? load_q :
                 (dp_off_q == 2'd1) ? value_q :
                 (dp_off_q == 2'd2) ? {16'h0000, prescale_q, 5'd0, ie_q, periodic_q, en_q} :
                                      {31'd0, irq_q};
        bus.HRDATA = (dp_valid_q & ~dp_write_q) ? rd_mux : 32'h0;
    end

    assign bus.HREADYOUT = (state_q != ERR1);
    assign bus.HRESP     = (state_q == OK) ? 2'b00 : 2'b01;
    assign TIMINT        = irq_q & ie_q;

    // State registers; reset aborts any error response and discards the count
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= OK;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_off_q   <= 2'd0;
            load_q     <= LOAD_RST;
            value_q    <= LOAD_RST;
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            ie_q       <= 1'b0;
            prescale_q <= PRESCALE_RST;
            irq_q      <= 1'b0;
            pcnt_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_off_q   <= dp_off_d;
            load_q     <= load_d;
            value_q    <= value_d;
            en_q       <= en_d;
            periodic_q <= periodic_d;
            ie_q       <= ie_d;
            prescale_q <= prescale_d;
            irq_q      <= irq_d;
            pcnt_q     <= pcnt_d;
        end
    end
endmodule

// File: tb/tb_ahb_timer_slave.sv
// tb_ahb_timer_slave: scoreboard bench for the AHB timer slave with a cycle-level reference model
module tb_ahb_timer_slave;
    logic HCLK = 1'b0;
    logic HRESET;
    logic TIMINT;
    ahb_timer_slave_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_timer_slave dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus.slave), .TIMINT(TIMINT));

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit        rst;
        bit        sel;
        bit [1:0]  trans;
        bit        wr;
        bit [31:0] addr;
        bit [2:0]  size;
        bit [31:0] wdata;
        bit        has_exp;
        bit [31:0] exp_val;
    } xfer_t;

    typedef struct {
        bit        chk;
        bit        ready;
        bit [1:0]  resp;
        bit [31:0] rdata;
        bit        timint;
    } resp_t;

    xfer_t stim_q[$];
    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    bit [31:0] m_load, m_value;
    bit        m_en, m_per, m_ie, m_irq, m_known;
    bit [7:0]  m_pre, m_pcnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit [31:0] m_reg(input bit [1:0] off);
        case (off)
            2'd0:    return m_load;
            2'd1:    return m_value;
            2'd2:    return {16'h0, m_pre, 5'd0, m_ie, m_per, m_en};
            default: return {31'd0, m_irq};
        endcase
    endfunction

    task automatic model_reset();
        m_load = 0; m_value = 0; m_en = 0; m_per = 0; m_ie = 0; m_pre = 0; m_irq = 0; m_pcnt = 0;
    endtask

    // One HCLK edge of the timer as the register map describes it
    task automatic model_edge(input bit do_wr, input bit [1:0] off, input bit [31:0] d);
        bit        tick, expire, en, irq;
        bit [31:0] v;
        bit [7:0]  p;
        tick   = m_en && (m_pcnt == m_pre);
        expire = tick && (m_value == 0);
        v = m_value; p = m_pcnt; en = m_en; irq = m_irq;
        if (m_en) p = tick ? 8'd0 : m_pcnt + 8'd1;
        if (tick && !expire) v = m_value - 1;
        if (expire) begin
            irq = 1;
            if (m_per) v = m_load;
            else en = 0;
        end
        if (do_wr) begin
            case (off)
                2'd0: begin m_load = d; v = d; p = 0; end
                2'd2: begin
                    if (!m_en && d[0]) p = 0;
                    en = d[0]; m_per = d[1]; m_ie = d[2]; m_pre = d[15:8];
                end
                2'd3: if (d[0] && !expire) irq = 0;
                default: ;
            endcase
        end
        m_value = v; m_pcnt = p; m_en = en; m_irq = irq;
    endtask

    function automatic xfer_t mk(bit sel, bit [1:0] tr, bit wr, bit [31:0] addr, bit [2:0] sz, bit [31:0] wd);
        xfer_t x = '{default: '0};
        x.sel = sel; x.trans = tr; x.wr = wr; x.addr = addr; x.size = sz; x.wdata = wd;
        return x;
    endfunction

    task automatic push_wr(input bit [31:0] a, input bit [31:0] d);
        stim_q.push_back(mk(1, 2'b10, 1, a, 3'b010, d));
    endtask

    task automatic push_rdx(input bit [31:0] a, input bit [31:0] v);
        xfer_t x = mk(1, 2'b10, 0, a, 3'b010, 32'h0);
        x.has_exp = 1; x.exp_val = v;
        stim_q.push_back(x);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(mk(0, 2'b00, 0, 0, 3'b010, 32'hFFFF_FFFF));
    endtask

    task automatic push_rst(input int n);
        for (int i = 0; i < n; i++) begin
            xfer_t x = '{default: '0};
            x.rst = 1;
            stim_q.push_back(x);
        end
    endtask

    task automatic build_directed();
        push_rst(2);
        push_rdx(32'h5000_0000, 0); push_rdx(32'h5000_0004, 0);
        push_rdx(32'h5000_0008, 0); push_rdx(32'h5000_000C, 0);
        push_wr(32'h5000_0000, 3); push_wr(32'h5000_0008, 32'h7);
        push_rdx(32'h5000_0004, 3); push_rdx(32'h5000_0004, 2); push_rdx(32'h5000_0004, 1);
        push_rdx(32'h5000_0004, 0); push_rdx(32'h5000_0004, 3); push_rdx(32'h5000_000C, 1);
        push_wr(32'h5000_0008, 0); push_wr(32'h5000_000C, 1);
        push_rdx(32'h5000_000C, 0); push_rdx(32'h5000_0008, 0);
        push_wr(32'h5000_0000, 1); push_wr(32'h5000_0008, 32'h205);
        push_idle(8);
        push_rdx(32'h5000_0008, 32'h204); push_rdx(32'h5000_0004, 0); push_rdx(32'h5000_000C, 1);
        push_wr(32'h5000_000C, 1);
        stim_q.push_back(mk(1, 2'b10, 0, 32'h5000_0010, 3'b010, 0));
        stim_q.push_back(mk(1, 2'b10, 1, 32'h5000_0000, 3'b001, 32'hDEAD));
        push_rdx(32'h5000_0000, 1);
        push_wr(32'h5000_0000, 32'hA5); push_rdx(32'h5000_0004, 32'hA5);
        stim_q.push_back(mk(1, 2'b00, 1, 32'h5000_0000, 3'b010, 32'h1234));
        stim_q.push_back(mk(1, 2'b01, 1, 32'h5000_0000, 3'b010, 32'h5678));
        stim_q.push_back(mk(0, 2'b10, 1, 32'h5000_0000, 3'b010, 32'h9ABC));
        push_rdx(32'h5000_0000, 32'hA5); push_rdx(32'h5000_0004, 32'hA5);
        push_wr(32'h5000_0000, 1); push_wr(32'h5000_0008, 32'h7);
        push_idle(3);
        stim_q.push_back(mk(1, 2'b10, 0, 32'h5000_0020, 3'b010, 0));
        push_rst(1);
        push_rdx(32'h5000_0000, 0); push_rdx(32'h5000_0004, 0);
        push_rdx(32'h5000_0008, 0); push_rdx(32'h5000_000C, 0);
    endtask

    task automatic build_random(input int n);
        for (int i = 0; i < n; i++) begin
            xfer_t x = '{default: '0};
            if ($urandom_range(0, 99) == 0) begin
                x.rst = 1;
            end else begin
                x.sel   = $urandom_range(0, 9) != 0;
                x.trans = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
                x.wr    = 1'($urandom_range(0, 1));
                x.addr  = $urandom;
                x.addr[11:4] = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00;
                x.addr[1:0]  = 2'b00;
                x.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
                case (x.addr[3:2])
                    2'd0:    x.wdata = $urandom_range(0, 12);
                    2'd2:    x.wdata = $urandom & 32'hFFFF_03FF;
                    default: x.wdata = $urandom;
                endcase
            end
            stim_q.push_back(x);
        end
    endtask

    // Monitor: one expected response per cycle, checked mid-cycle
    always @(negedge HCLK) begin
        if (exp_q.size() != 0) begin
            resp_t e;
            e = exp_q.pop_front();
            if (e.chk) begin
                check("HREADYOUT", bus.HREADYOUT, e.ready);
                check("HRESP", bus.HRESP, e.resp);
                check("HRDATA", bus.HRDATA, e.rdata);
                check("TIMINT", TIMINT, e.timint);
            end
        end
    end

    xfer_t     a;
    resp_t     r;
    bit        consumed, ready, acc, lg, dpv, dpw, dpx;
    bit [1:0]  es, dpoff;
    bit [31:0] dpwd, dpexp;
    int        tail;

    initial begin
        HRESET = 1; bus.HSEL = 0; bus.HADDR = 0; bus.HTRANS = 0; bus.HWRITE = 0;
        bus.HSIZE = 3'b010; bus.HWDATA = 0;
        model_reset(); m_known = 0;
        consumed = 1; es = 0; dpv = 0; dpw = 0; dpx = 0; dpoff = 0; dpwd = 0; dpexp = 0; tail = 0;
        build_directed();
        build_random(3000);
        @(posedge HCLK); #1;
        while (stim_q.size() != 0 || tail < 4) begin
            if (stim_q.size() == 0) tail++;
            if (consumed) a = (stim_q.size() != 0) ? stim_q.pop_front() : mk(0, 2'b00, 0, 0, 3'b010, 0);
            ready    = (es != 2'd1);
            r.chk    = m_known;
            r.ready  = ready;
            r.resp   = (es != 2'd0) ? 2'b01 : 2'b00;
            r.rdata  = (dpv && !dpw) ? (dpx ? dpexp : m_reg(dpoff)) : 32'h0;
            r.timint = m_irq & m_ie;
            exp_q.push_back(r);
            HRESET = a.rst; bus.HSEL = a.sel; bus.HTRANS = a.trans; bus.HWRITE = a.wr;
            bus.HADDR = a.addr; bus.HSIZE = a.size; bus.HWDATA = dpwd;
            @(posedge HCLK);
            if (a.rst) begin
                model_reset(); m_known = 1; es = 0; dpv = 0; consumed = 1;
            end else begin
                model_edge(ready && dpv && dpw, dpoff, dpwd);
                if (ready) begin
                    acc = a.sel && a.trans[1];
                    lg  = (a.addr[11:4] == 8'h00) && (a.size == 3'b010);
                    dpv = acc && lg; dpw = a.wr; dpoff = a.addr[3:2]; dpwd = a.wdata;
                    dpx = a.has_exp; dpexp = a.exp_val;
                    es  = (acc && !lg) ? 2'd1 : 2'd0;
                end else begin
                    es = 2'd2;
                end
                consumed = ready;
            end
            #1;
        end
        repeat (2) @(negedge HCLK);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
